// File: rtl/cayde_rtype_seq_if.sv
// Bundle between the R-type sequencer, the fetch stage and the register file / ALU.
// The master modport is the sequencer side; the slave modport is the environment side.
interface cayde_rtype_seq_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     instr;
  logic [4:0]      rf_raddr1;
  logic [4:0]      rf_raddr2;
  logic [XLEN-1:0] rf_rdata1;
  logic [XLEN-1:0] rf_rdata2;
  logic [6:0]      alu_op;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_result;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            done;
  logic            illegal;
  logic            busy;
  logic [31:0]     retired_cnt;

  modport master (
    input  instr_valid, instr, rf_rdata1, rf_rdata2, alu_result,
    output instr_ready, rf_raddr1, rf_raddr2, alu_op, alu_a, alu_b,
           rf_we, rf_waddr, rf_wdata, done, illegal, busy, retired_cnt
  );

  modport slave (
    output instr_valid, instr, rf_rdata1, rf_rdata2, alu_result,
    input  instr_ready, rf_raddr1, rf_raddr2, alu_op, alu_a, alu_b,
           rf_we, rf_waddr, rf_wdata, done, illegal, busy, retired_cnt
  );
endinterface

// File: rtl/cayde_rtype_seq.sv
// Multi-cycle R-type sequencer: accept, decode to ALU op, read RF, execute, write back.
// Illegal encodings divert to a one-cycle trap state without touching the register file.
module cayde_rtype_seq #(
  parameter int unsigned XLEN = 32
) (
  input logic               clk,
  input logic               rst,
  cayde_rtype_seq_if.master bus_io
);

  localparam logic [6:0] OPCODE_OP = 7'b0110011;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StRead = 3'd1;
  localparam logic [2:0] StExec = 3'd2;
  localparam logic [2:0] StWb   = 3'd3;
  localparam logic [2:0] StTrap = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [4:0]      rs1_q, rs1_d;
  logic [4:0]      rs2_q, rs2_d;
  logic [4:0]      rd_q, rd_d;
  logic [6:0]      op_q, op_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [31:0]     retired_cnt_q, retired_cnt_d;

  logic       dec_legal;
  logic       funct_ok;
  logic [6:0] dec_op;

  // Decode straight from the bus so the op code is ready when the word is latched.
  always_comb begin
    funct_ok = 1'b1;
    dec_op   = 7'd0;
    case ({bus_io.instr[31:25], bus_io.instr[14:12]})
      10'b0000000_000: dec_op = 7'd0;
      10'b0100000_000: dec_op = 7'd1;
      10'b0000000_100: dec_op = 7'd2;
      10'b0000000_111: dec_op = 7'd3;
      10'b0000000_110: dec_op = 7'd4;
      10'b0000000_001: dec_op = 7'd5;
      10'b0000000_010: dec_op = 7'd6;
      10'b0000000_011: dec_op = 7'd7;
      10'b0000000_101: dec_op = 7'd8;
      10'b0100000_101: dec_op = 7'd9;
      default:         funct_ok = 1'b0;
    endcase
    dec_legal = funct_ok && (bus_io.instr[6:0] == OPCODE_OP);
  end

  always_comb begin
    state_d       = state_q;
    rs1_d         = rs1_q;
    rs2_d         = rs2_q;
    rd_d          = rd_q;
    op_d          = op_q;
    result_d      = result_q;
    retired_cnt_d = retired_cnt_q;
    case (state_q)
      StIdle: begin
        if (bus_io.instr_valid) begin
          rs1_d   = bus_io.instr[19:15];
          rs2_d   = bus_io.instr[24:20];
          rd_d    = bus_io.instr[11:7];
          op_d    = dec_legal ? dec_op : 7'd0;
          state_d = dec_legal ? StRead : StTrap;
        end
      end
      StRead: state_d = StExec;
      StExec: begin
        result_d = bus_io.alu_result;
        state_d  = StWb;
      end
      StWb: begin
        retired_cnt_d = retired_cnt_q + 32'd1;
        state_d       = StIdle;
      end
      StTrap:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      rs1_q         <= '0;
      rs2_q         <= '0;
      rd_q          <= '0;
      op_q          <= '0;
      result_q      <= '0;
      retired_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      rs1_q         <= rs1_d;
      rs2_q         <= rs2_d;
      rd_q          <= rd_d;
      op_q          <= op_d;
      result_q      <= result_d;
      retired_cnt_q <= retired_cnt_d;
    end
  end

  // Every output is a pure function of the state, so reset values follow from StIdle.
  always_comb begin
    bus_io.instr_ready = (state_q == StIdle);
    bus_io.busy        = (state_q != StIdle);
    bus_io.rf_raddr1   = 5'd0;
    bus_io.rf_raddr2   = 5'd0;
    bus_io.alu_op      = 7'd0;
    bus_io.alu_a       = '0;
    bus_io.alu_b       = '0;
    bus_io.rf_we       = 1'b0;
    bus_io.rf_waddr    = 5'd0;
    bus_io.rf_wdata    = '0;
    bus_io.done        = 1'b0;
    bus_io.illegal     = 1'b0;
    bus_io.retired_cnt = retired_cnt_q;
    case (state_q)
      StRead: begin
        bus_io.rf_raddr1 = rs1_q;
        bus_io.rf_raddr2 = rs2_q;
      end
      StExec: begin
        bus_io.alu_op = op_q;
        bus_io.alu_a  = bus_io.rf_rdata1;
        bus_io.alu_b  = bus_io.rf_rdata2;
      end
      StWb: begin
        bus_io.rf_we    = (rd_q != 5'd0);
        bus_io.rf_waddr = rd_q;
        bus_io.rf_wdata = result_q;
        bus_io.done     = 1'b1;
      end
      StTrap:  bus_io.illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cayde_rtype_seq.sv
// Randomized bench for cayde_rtype_seq: register-file/ALU environment plus an
// instruction-level reference model that predicts every handshake cycle.
module tb_cayde_rtype_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cayde_rtype_seq_if #(.XLEN(32)) bus ();

  cayde_rtype_seq #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  logic [31:0] env_rf [32];
  logic [31:0] ref_rf [32];
  logic [31:0] ref_cnt;
  logic        ld_en;
  logic [4:0]  ld_addr;
  logic [31:0] ld_data;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  localparam logic [9:0] LegalKeys [10] = '{
    10'b0000000_000, 10'b0100000_000, 10'b0000000_100, 10'b0000000_111, 10'b0000000_110,
    10'b0000000_001, 10'b0000000_010, 10'b0000000_011, 10'b0000000_101, 10'b0100000_101
  };

  // Environment register file: synchronous read, x0 hardwired to zero.
  always @(posedge clk) begin
    bus.rf_rdata1 <= env_rf[bus.rf_raddr1];
    bus.rf_rdata2 <= env_rf[bus.rf_raddr2];
    if (ld_en) env_rf[ld_addr] <= ld_data;
    else if (bus.rf_we && bus.rf_waddr != 5'd0) env_rf[bus.rf_waddr] <= bus.rf_wdata;
  end

  // Environment ALU keyed by the core's op code.
  always_comb begin
    bus.alu_result = 32'hDEAD_BEEF;
    case (bus.alu_op)
      7'd0: bus.alu_result = bus.alu_a + bus.alu_b;
      7'd1: bus.alu_result = bus.alu_a - bus.alu_b;
      7'd2: bus.alu_result = bus.alu_a ^ bus.alu_b;
      7'd3: bus.alu_result = bus.alu_a & bus.alu_b;
      7'd4: bus.alu_result = bus.alu_a | bus.alu_b;
      7'd5: bus.alu_result = bus.alu_a << bus.alu_b[4:0];
      7'd6: bus.alu_result = {31'd0, $signed(bus.alu_a) < $signed(bus.alu_b)};
      7'd7: bus.alu_result = {31'd0, bus.alu_a < bus.alu_b};
      7'd8: bus.alu_result = bus.alu_a >> bus.alu_b[4:0];
      7'd9: bus.alu_result = $signed(bus.alu_a) >>> bus.alu_b[4:0];
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Instruction semantics from the mnemonic rules, independent of the op-code numbering path.
  function automatic void ref_model(input logic [31:0] ins, input logic [31:0] a,
                                    input logic [31:0] b, output logic legal,
                                    output logic [6:0] op, output logic [31:0] res);
    logic [6:0] f7;
    logic [2:0] f3;
    f7 = ins[31:25];
    f3 = ins[14:12];
    legal = 1'b1;
    op    = 7'd0;
    res   = 32'd0;
    if (ins[6:0] != 7'b0110011) legal = 1'b0;
    else if (f7 == 7'h00 && f3 == 3'd0) begin op = 7'd0; res = a + b; end
    else if (f7 == 7'h20 && f3 == 3'd0) begin op = 7'd1; res = a - b; end
    else if (f7 == 7'h00 && f3 == 3'd4) begin op = 7'd2; res = a ^ b; end
    else if (f7 == 7'h00 && f3 == 3'd7) begin op = 7'd3; res = a & b; end
    else if (f7 == 7'h00 && f3 == 3'd6) begin op = 7'd4; res = a | b; end
    else if (f7 == 7'h00 && f3 == 3'd1) begin op = 7'd5; res = a << b[4:0]; end
    else if (f7 == 7'h00 && f3 == 3'd2) begin op = 7'd6; res = ($signed(a) < $signed(b)) ? 1 : 0; end
    else if (f7 == 7'h00 && f3 == 3'd3) begin op = 7'd7; res = (a < b) ? 1 : 0; end
    else if (f7 == 7'h00 && f3 == 3'd5) begin op = 7'd8; res = a >> b[4:0]; end
    else if (f7 == 7'h20 && f3 == 3'd5) begin op = 7'd9; res = $signed(a) >>> b[4:0]; end
    else legal = 1'b0;
  endfunction

  function automatic logic [31:0] enc(input logic [9:0] key, input logic [4:0] rs2,
                                      input logic [4:0] rs1, input logic [4:0] rd);
    return {key[9:3], rs2, rs1, key[2:0], rd, 7'b0110011};
  endfunction

  task automatic rf_load(input logic [4:0] addr, input logic [31:0] data);
    ld_en   = 1'b1;
    ld_addr = addr;
    ld_data = (addr == 5'd0) ? 32'd0 : data;
    @(posedge clk);
    @(negedge clk);
    ld_en = 1'b0;
    ref_rf[addr] = ld_data;
  endtask

  // Entered and left on a negedge; keeps instr_valid high with junk while busy.
  task automatic issue(input logic [31:0] ins);
    logic        legal;
    logic [6:0]  eop;
    logic [31:0] eres;
    logic [4:0]  rs1, rs2, rd;
    rs1 = ins[19:15];
    rs2 = ins[24:20];
    rd  = ins[11:7];
    ref_model(ins, ref_rf[rs1], ref_rf[rs2], legal, eop, eres);
    bus.instr_valid = 1'b1;
    bus.instr       = ins;
    check("ready_before_accept", {31'd0, bus.instr_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.instr = $urandom;
    check("ready_low_busy", {30'd0, bus.instr_ready, bus.busy}, 32'd1);
    check("rf_we_c1", {31'd0, bus.rf_we}, 32'd0);
    check("done_c1", {31'd0, bus.done}, 32'd0);
    if (legal) begin
      check("illegal_c1", {31'd0, bus.illegal}, 32'd0);
      check("raddr1", {27'd0, bus.rf_raddr1}, {27'd0, rs1});
      check("raddr2", {27'd0, bus.rf_raddr2}, {27'd0, rs2});
      @(negedge clk);
      check("alu_op", {25'd0, bus.alu_op}, {25'd0, eop});
      check("alu_a", bus.alu_a, ref_rf[rs1]);
      check("alu_b", bus.alu_b, ref_rf[rs2]);
      check("done_c2", {31'd0, bus.done}, 32'd0);
      @(negedge clk);
      bus.instr_valid = 1'b0;
      check("done_wb", {30'd0, bus.done, bus.illegal}, 32'd2);
      check("rf_we_wb", {31'd0, bus.rf_we}, {31'd0, rd != 5'd0});
      check("waddr", {27'd0, bus.rf_waddr}, {27'd0, rd});
      check("wdata", bus.rf_wdata, eres);
      if (rd != 5'd0) ref_rf[rd] = eres;
      ref_cnt = ref_cnt + 32'd1;
    end else begin
      bus.instr_valid = 1'b0;
      check("illegal_c1", {31'd0, bus.illegal}, 32'd1);
      check("alu_op_trap", {25'd0, bus.alu_op}, 32'd0);
    end
    @(negedge clk);
    check("ready_idle", {30'd0, bus.instr_ready, bus.busy}, 32'd2);
    check("pulses_idle", {29'd0, bus.done, bus.illegal, bus.rf_we}, 32'd0);
    check("retired_cnt", bus.retired_cnt, ref_cnt);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int unsigned kind;
    kind = $urandom_range(0, 7);
    w = enc(LegalKeys[$urandom_range(0, 9)], 5'($urandom), 5'($urandom), 5'($urandom));
    if (kind == 5) w[31:25] = 7'b0000001;
    else if (kind == 6) w[6:0] = 7'($urandom);
    else if (kind == 7) w = $urandom;
    return w;
  endfunction

  initial begin
    rst             = 1'b1;
    ld_en           = 1'b0;
    ld_addr         = 5'd0;
    ld_data         = 32'd0;
    bus.instr_valid = 1'b0;
    bus.instr       = 32'd0;
    ref_cnt         = 32'd0;
    @(negedge clk);
    for (int i = 0; i < 32; i++) rf_load(5'(i), $urandom);
    check("rst_ready_busy", {30'd0, bus.instr_ready, bus.busy}, 32'd2);
    check("rst_pulses", {29'd0, bus.done, bus.illegal, bus.rf_we}, 32'd0);
    check("rst_alu", {bus.alu_a[15:0], bus.alu_b[8:0], bus.alu_op}, 32'd0);
    check("rst_rf", {bus.rf_raddr1, bus.rf_raddr2, bus.rf_waddr, 17'd0}, 32'd0);
    check("rst_wdata", bus.rf_wdata, 32'd0);
    check("rst_cnt", bus.retired_cnt, 32'd0);
    rst = 1'b0;

    rf_load(5'd1, 32'd5);
    rf_load(5'd2, 32'd7);
    issue(32'h002081B3);
    check("add_result_x3", ref_rf[3], 32'd12);

    issue(enc(10'b0100000_000, 5'd2, 5'd1, 5'd4));
    issue(enc(10'b0100000_101, 5'd2, 5'd3, 5'd5));
    issue(enc(10'b0000000_101, 5'd2, 5'd3, 5'd6));
    issue(enc(10'b0000000_011, 5'd6, 5'd5, 5'd7));

    issue(enc(10'b0000001_000, 5'd2, 5'd1, 5'd8));
    issue({12'h005, 5'd1, 3'd0, 5'd9, 7'b0010011});
    issue(enc(10'b0000000_000, 5'd2, 5'd1, 5'd0));

    for (int n = 0; n < 60; n++) issue(rand_instr());

    // Reset while in EXEC discards the instruction.
    bus.instr_valid = 1'b1;
    bus.instr       = enc(10'b0000000_000, 5'd2, 5'd1, 5'd10);
    @(posedge clk);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ref_cnt = 32'd0;
    check("rst_exec_idle", {30'd0, bus.instr_ready, bus.busy}, 32'd2);
    check("rst_exec_pulses", {30'd0, bus.done, bus.rf_we}, 32'd0);
    check("rst_exec_cnt", bus.retired_cnt, 32'd0);
    @(negedge clk);
    check("rst_exec_no_late_done", {30'd0, bus.done, bus.rf_we}, 32'd0);

    // Reset wins over a simultaneous handshake.
    rst             = 1'b1;
    bus.instr_valid = 1'b1;
    bus.instr       = enc(10'b0000000_000, 5'd2, 5'd1, 5'd11);
    @(posedge clk);
    @(negedge clk);
    rst             = 1'b0;
    bus.instr_valid = 1'b0;
    check("rst_prio_idle", {30'd0, bus.instr_ready, bus.busy}, 32'd2);
    @(negedge clk);
    check("rst_prio_still_idle", {31'd0, bus.busy}, 32'd0);

    // Counter wrap.
    force dut.retired_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_cnt_q;
    ref_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    check("cnt_preload", bus.retired_cnt, ref_cnt);
    issue(enc(10'b0000000_110, 5'd2, 5'd1, 5'd12));
    check("cnt_wrapped", bus.retired_cnt, 32'd0);

    for (int n = 0; n < 20; n++) issue(rand_instr());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
